lock_range_sweeper: RTL and testbench
=====================================

# lock_range_sweeper

Sequencer that measures the ADPLL lock range on the FPGA. It drives the k value and enable of the reference PhaseAccum, steps k across a programmed range, and waits a settle interval at each point. It then checks the ADPLL signed phase error over a dwell window and records the lowest and highest k at which the loop held lock. It sits between the switch/config logic and the PhaseAccum/ADPLL pair in the fpga_clk (258 MHz) domain.

## Interface
- K_WIDTH, 16, width of PhaseAccum k value
- ERR_WIDTH, 8, width of ADPLL signed error
- SETTLE_CYCLES, 1024, cycles ignored after each k change (≥1)
- DWELL_CYCLES, 4096, cycles error is checked per point (≥1)
- LOCK_TOL, 2, max |error| counted as locked
- fpga_clk_i  in  1  sweep clock, same clock as PhaseAccum/ADPLL
- reset_i  in  1  asynchronous, active-high reset
- start_i  in  1  begin sweep (sampled in IDLE only)
- abort_i  in  1  terminate sweep
- k_start_i, k_stop_i, k_step_i  in  K_WIDTH each  sweep bounds and increment, captured at start
- error_i  in  ERR_WIDTH signed  ADPLL phase error
- k_val_o  out  K_WIDTH  k to PhaseAccum, registered
- osc_enable_o  out  1  PhaseAccum enable
- busy_o  out  1  sweep in progress
- done_o  out  1  one-cycle pulse at sweep completion
- found_o  out  1  at least one locked point
- lock_lo_o, lock_hi_o  out  K_WIDTH  first/last locked k

## Operation
- States: IDLE, SETTLE, DWELL, STEP, DONE.
- IDLE: start_i=1 and abort_i=0 → capture config, k_val_o←k_start_i, clear found/lock_lo/lock_hi, go to SETTLE. start_i outside IDLE is ignored.
- SETTLE: count SETTLE_CYCLES and ignore error_i. Then go to DWELL with the point lock flag set.
- DWELL: each cycle compute |error_i|. −2^(ERR_WIDTH−1) saturates to 2^(ERR_WIDTH−1)−1. Any |error_i| > LOCK_TOL clears the point flag. After DWELL_CYCLES, go to STEP.
- STEP: if the point is locked: when found=0, set lock_lo←k and found←1; always set lock_hi←k. Then compute next = k + step in K_WIDTH+1 bits.
  - next > k_stop, or carry out → DONE.
  - Otherwise k_val_o←next, go to SETTLE.
- Degenerate configs:
  - k_step=0 → single point.
  - k_start>k_stop → single point at k_start.
- DONE: done_o=1 for one cycle, then IDLE. Results hold until the next accepted start.
- abort_i=1 in any non-IDLE state → IDLE next cycle. No done_o. Partial results are retained. Simultaneous start_i and abort_i in IDLE: abort wins, no sweep.
- osc_enable_o = busy_o. k_val_o holds its last value in IDLE.

## Timing
- Reset values: k_val_o=0, osc_enable_o=0, busy_o=0, done_o=0, found_o=0, lock_lo_o=0, lock_hi_o=0, state IDLE.
- Accepting start at edge N:
  - At N+1: busy_o=1, osc_enable_o=1, and k_val_o=k_start.
- Per-point period is SETTLE_CYCLES+DWELL_CYCLES+1 cycles. k_val_o changes on the cycle after STEP.
- A sweep of P points asserts done_o P·(SETTLE_CYCLES+DWELL_CYCLES+1) cycles after busy_o rises. busy_o is low in the done_o cycle.
- found_o, lock_lo_o and lock_hi_o update at the end of STEP, so they are valid the cycle after STEP.
- error_i is sampled on every DWELL clock edge with no pipelining. An asynchronous reset mid-sweep returns all outputs to their reset values immediately.

## Configuration
- LOCK_SWEEP_EARLY_STOP_EN defined: in STEP, an unlocked point with found=1 goes straight to DONE. Only the first contiguous lock range is reported.
- Not defined: the full range is always swept. lock_lo_o/lock_hi_o span the first to last locked points, including any unlocked gaps between them.

## Structure
- Package lock_sweep_pkg holds:
  - state enum sweep_state_t
  - sat_abs function (saturating absolute value, parameterised by width)
  - default constants for SETTLE/DWELL/LOCK_TOL
- One sub-module, lock_window_check:
  - Contains the DWELL counter and the |error|≤LOCK_TOL accumulator.
  - Controls: clear, enable. Outputs: window_done, window_locked.
- The parent module holds the FSM, the k arithmetic and the result registers.

## Test plan
Bench parameters: SETTLE_CYCLES=4, DWELL_CYCLES=8, LOCK_TOL=2, K_WIDTH=16, ERR_WIDTH=8.
- Reset asserted mid-DWELL → all outputs 0 immediately. After release, stays IDLE until start_i.
- start=100, stop=140, step=10, error model 0 for k∈[110,130] else 50 → five points, done_o at cycle 65 after busy_o rises, found_o=1, lock_lo_o=110, lock_hi_o=130.
- error_i fixed at −128 → saturation handled, found_o=0, lock_lo_o=lock_hi_o=0, done_o after full range.
- start=0xFFF0, stop=0xFFFF, step=0x0020 → single point, no wrap to 0x0010, done_o after 13 cycles. step=0 behaves the same.
- At k=120, error_i=10 for one DWELL cycle → 120 is unlocked. The same glitch during SETTLE → 120 is locked. With LOCK_SWEEP_EARLY_STOP_EN and the DWELL glitch, done_o comes at k=120 with lock_hi_o=110.
- abort_i during the second DWELL → IDLE next cycle, no done_o, osc_enable_o=0. start_i together with abort_i in IDLE → no sweep.

Source files
------------

// File: rtl/lock_sweep_pkg.sv
// Shared types and helpers for the ADPLL lock-range sweeper.
package lock_sweep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_DWELL,
        ST_STEP,
        ST_DONE
    } sweep_state_t;

    localparam int unsigned SETTLE_CYCLES_DEF = 1024;
    localparam int unsigned DWELL_CYCLES_DEF  = 4096;
    localparam int unsigned LOCK_TOL_DEF      = 2;

    // |x| for a sign-extended width-bit value; the most negative code maps to the max positive.
    function automatic logic [31:0] sat_abs(input logic signed [31:0] x, input int unsigned width);
        logic signed [31:0] lim;
        lim = 32'sd1 <<< (width - 1);
        if (x == -lim) begin
            return unsigned'(32'(lim - 32'sd1));
        end
        if (x < 0) begin
            return unsigned'(32'(-x));
        end
        return unsigned'(32'(x));
    endfunction

endpackage

// File: rtl/lock_window_check.sv
// Dwell-window counter and per-point lock accumulator (|error| <= LOCK_TOL on every cycle).
module lock_window_check
    import lock_sweep_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = DWELL_CYCLES_DEF,
    parameter int unsigned ERR_WIDTH    = 8,
    parameter int unsigned LOCK_TOL     = LOCK_TOL_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [ERR_WIDTH-1:0] error_i,
    output logic                 window_done,
    output logic                 window_locked
);

    localparam int unsigned CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             locked_q, locked_d;
    logic [31:0]      err_abs_c;

    assign err_abs_c     = sat_abs(32'(signed'(error_i)), ERR_WIDTH);
    assign window_done   = enable && (cnt_q == CNT_W'(DWELL_CYCLES - 1));
    assign window_locked = locked_q;

    always_comb begin
        cnt_d    = cnt_q;
        locked_d = locked_q;
        if (clear) begin
            cnt_d    = '0;
            locked_d = 1'b1;
        end else if (enable) begin
            if (err_abs_c > LOCK_TOL) begin
                locked_d = 1'b0;
            end
            cnt_d = window_done ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
        end
    end

endmodule

// File: rtl/lock_range_sweeper.sv
// Steps PhaseAccum k across a range and records the lowest/highest k where the ADPLL held lock.
// Define LOCK_SWEEP_EARLY_STOP_EN to end the sweep at the first unlocked point after a lock.
module lock_range_sweeper
    import lock_sweep_pkg::*;
#(
    parameter int unsigned K_WIDTH       = 16,
    parameter int unsigned ERR_WIDTH     = 8,
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int unsigned DWELL_CYCLES  = DWELL_CYCLES_DEF,
    parameter int unsigned LOCK_TOL      = LOCK_TOL_DEF
) (
    input  logic                 fpga_clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [K_WIDTH-1:0]   k_start_i,
    input  logic [K_WIDTH-1:0]   k_stop_i,
    input  logic [K_WIDTH-1:0]   k_step_i,
    input  logic [ERR_WIDTH-1:0] error_i,
    output logic [K_WIDTH-1:0]   k_val_o,
    output logic                 osc_enable_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 found_o,
    output logic [K_WIDTH-1:0]   lock_lo_o,
    output logic [K_WIDTH-1:0]   lock_hi_o
);

    localparam int unsigned SCNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    sweep_state_t       state_q, state_d;
    logic [K_WIDTH-1:0] k_q, k_d;
    logic [K_WIDTH-1:0] stop_q, stop_d;
    logic [K_WIDTH-1:0] step_q, step_d;
    logic [K_WIDTH-1:0] lo_q, lo_d;
    logic [K_WIDTH-1:0] hi_q, hi_d;
    logic               found_q, found_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [SCNT_W-1:0]  scnt_q, scnt_d;
    logic               win_clear, win_en, win_done, win_locked;
    logic [K_WIDTH:0]   next_k_c;

    lock_window_check #(
        .DWELL_CYCLES (DWELL_CYCLES),
        .ERR_WIDTH    (ERR_WIDTH),
        .LOCK_TOL     (LOCK_TOL)
    ) u_window (
        .clk           (fpga_clk_i),
        .rst           (reset_i),
        .clear         (win_clear),
        .enable        (win_en),
        .error_i       (error_i),
        .window_done   (win_done),
        .window_locked (win_locked)
    );

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        stop_d    = stop_q;
        step_d    = step_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        found_d   = found_q;
        scnt_d    = scnt_q;
        win_clear = 1'b0;
        win_en    = 1'b0;
        // One extra bit so a wrap past the top of the k range is visible as carry.
        next_k_c  = {1'b0, k_q} + {1'b0, step_q};

        case (state_q)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    k_d     = k_start_i;
                    stop_d  = k_stop_i;
                    step_d  = k_step_i;
                    found_d = 1'b0;
                    lo_d    = '0;
                    hi_d    = '0;
                    scnt_d  = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (scnt_q == SCNT_W'(SETTLE_CYCLES - 1)) begin
                    scnt_d    = '0;
                    win_clear = 1'b1;
                    state_d   = ST_DWELL;
                end else begin
                    scnt_d = scnt_q + SCNT_W'(1);
                end
            end
            ST_DWELL: begin
                win_en = 1'b1;
                if (win_done) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                if (win_locked) begin
                    if (!found_q) begin
                        lo_d    = k_q;
                        found_d = 1'b1;
                    end
                    hi_d = k_q;
                end
                if ((step_q == '0) || next_k_c[K_WIDTH] || (next_k_c[K_WIDTH-1:0] > stop_q)) begin
                    state_d = ST_DONE;
                end
`ifdef LOCK_SWEEP_EARLY_STOP_EN
                else if (!win_locked && found_q) begin
                    state_d = ST_DONE;
                end
`endif
                else begin
                    k_d     = next_k_c[K_WIDTH-1:0];
                    scnt_d  = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort_i && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            k_d     = k_q;
        end

        busy_d = (state_d == ST_SETTLE) || (state_d == ST_DWELL) || (state_d == ST_STEP);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            stop_q  <= '0;
            step_q  <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            found_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            stop_q  <= stop_d;
            step_q  <= step_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            found_q <= found_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            scnt_q  <= scnt_d;
        end
    end

    assign k_val_o      = k_q;
    assign osc_enable_o = busy_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign found_o      = found_q;
    assign lock_lo_o    = lo_q;
    assign lock_hi_o    = hi_q;

endmodule

// File: tb/tb_lock_range_sweeper.sv
// Self-checking bench for lock_range_sweeper: timeline model of the sweep plus directed literal checks.
module tb_lock_range_sweeper;

    localparam int S   = 4;
    localparam int D   = 8;
    localparam int TOL = 2;
    localparam int L   = S + D + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, abort_i;
    logic [15:0] k_start, k_stop, k_step;
    logic [7:0]  err;
    logic [15:0] k_val_o, lock_lo_o, lock_hi_o;
    logic        osc_enable_o, busy_o, done_o, found_o;

    lock_range_sweeper #(
        .K_WIDTH       (16),
        .ERR_WIDTH     (8),
        .SETTLE_CYCLES (S),
        .DWELL_CYCLES  (D),
        .LOCK_TOL      (TOL)
    ) dut (
        .fpga_clk_i   (clk),
        .reset_i      (rst),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .k_start_i    (k_start),
        .k_stop_i     (k_stop),
        .k_step_i     (k_step),
        .error_i      (err),
        .k_val_o      (k_val_o),
        .osc_enable_o (osc_enable_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .found_o      (found_o),
        .lock_lo_o    (lock_lo_o),
        .lock_hi_o    (lock_hi_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Sweep model: list of visited points, their lock verdicts, and when the sweep began.
    int t0 = -1;
    int abort_rel = -1;
    int mode = 0;
    int pts[$];
    bit lkq[$];
    int idle_k = 0, idle_lo = 0, idle_hi = 0;
    bit idle_found = 1'b0;
    int done_rel = -1;
    int done_cnt = 0;

    function automatic int err_at(input int k, input int off);
        case (mode)
            0: return (k >= 110 && k <= 130) ? 0 : 50;
            1: return -128;
            2: return (off % 2 == 1) ? 2 : -2;
            3: begin
                if (k == 120 && off == S + 3) return 10;
                return (k >= 110 && k <= 130) ? 0 : 50;
            end
            4: begin
                if (k == 120 && off == 1) return 10;
                return (k >= 110 && k <= 130) ? 0 : 50;
            end
            5: return 3;
            default: return 0;
        endcase
    endfunction

    function automatic bit point_locked(input int k);
        for (int o = S; o < S + D; o++) begin
            int e;
            int a;
            e = err_at(k, o);
            a = (e < 0) ? -e : e;
            if (a > 127) a = 127;
            if (a > TOL) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic plan(input int s, input int e, input int st);
        int k;
        bit f;
        bit lk;
        k = s;
        f = 1'b0;
        pts.delete();
        lkq.delete();
        forever begin
            lk = point_locked(k);
            pts.push_back(k);
            lkq.push_back(lk);
`ifdef LOCK_SWEEP_EARLY_STOP_EN
            if (!lk && f) break;
`endif
            if (lk) f = 1'b1;
            if (st == 0 || k + st > 65535 || k + st > e) break;
            k = k + st;
        end
    endtask

    task automatic model_expect(input int c, output int ek, output bit eb, output bit ed,
                                output bit ef, output int elo, output int ehi);
        int rel, np, npc;
        bit aborted;
        ek = idle_k; eb = 1'b0; ed = 1'b0; ef = idle_found; elo = idle_lo; ehi = idle_hi;
        if (t0 >= 0 && c >= t0) begin
            rel = c - t0;
            np = pts.size();
            aborted = (abort_rel >= 0) && (rel >= abort_rel);
            npc = aborted ? abort_rel / L : rel / L;
            if (npc > np) npc = np;
            ef = 1'b0; elo = 0; ehi = 0;
            for (int i = 0; i < npc; i++) begin
                if (lkq[i]) begin
                    if (!ef) begin elo = pts[i]; ef = 1'b1; end
                    ehi = pts[i];
                end
            end
            if (aborted) begin
                ek = pts[((abort_rel - 1) / L < np) ? (abort_rel - 1) / L : np - 1];
            end else if (rel < np * L) begin
                eb = 1'b1;
                ek = pts[rel / L];
            end else begin
                ed = (rel == np * L);
                ek = pts[np - 1];
            end
        end
    endtask

    function automatic int drive_err(input int c);
        int rel;
        if (t0 < 0 || c < t0) return 0;
        rel = c - t0;
        if (abort_rel >= 0 && rel >= abort_rel) return 0;
        if (rel >= pts.size() * L) return 0;
        return err_at(pts[rel / L], rel % L);
    endfunction

    // Single compare process: every cycle, DUT outputs against the timeline model.
    always @(negedge clk) begin
        int ek, elo, ehi;
        bit eb, ed, ef;
        model_expect(cyc, ek, eb, ed, ef, elo, ehi);
        check("k_val_o", int'(k_val_o), ek);
        check("osc_enable_o", int'(osc_enable_o), int'(eb));
        check("busy_o", int'(busy_o), int'(eb));
        check("done_o", int'(done_o), int'(ed));
        check("found_o", int'(found_o), int'(ef));
        check("lock_lo_o", int'(lock_lo_o), elo);
        check("lock_hi_o", int'(lock_hi_o), ehi);
        if (done_o === 1'b1) begin
            done_cnt++;
            if (done_rel < 0 && t0 >= 0) done_rel = cyc - t0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        err = 8'(drive_err(cyc));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_sweep(input int s, input int e, input int st, input int m);
        int ek, elo, ehi;
        bit eb, ed, ef;
        model_expect(cyc, ek, eb, ed, ef, elo, ehi);
        idle_k = ek; idle_found = ef; idle_lo = elo; idle_hi = ehi;
        mode = m;
        plan(s, e, st);
        t0 = cyc + 1;
        abort_rel = -1;
        done_rel = -1;
        done_cnt = 0;
        k_start = 16'(s);
        k_stop  = 16'(e);
        k_step  = 16'(st);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic check_results(input string tag, input int d_rel, input int f, input int lo, input int hi);
        check({tag, " done_rel"}, done_rel, d_rel);
        check({tag, " found"}, int'(found_o), f);
        check({tag, " lock_lo"}, int'(lock_lo_o), lo);
        check({tag, " lock_hi"}, int'(lock_hi_o), hi);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " k_val"}, int'(k_val_o), 0);
        check({tag, " osc_en"}, int'(osc_enable_o), 0);
        check({tag, " busy"}, int'(busy_o), 0);
        check({tag, " done"}, int'(done_o), 0);
        check({tag, " found"}, int'(found_o), 0);
        check({tag, " lock_lo"}, int'(lock_lo_o), 0);
        check({tag, " lock_hi"}, int'(lock_hi_o), 0);
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; abort_i = 1'b0;
        k_start = '0; k_stop = '0; k_step = '0; err = '0;
        #2;
        check_all_zero("por");
        run(2);
        rst = 1'b0;
        run(3);

        // Nominal sweep: lock band 110..130.
        start_sweep(100, 140, 10, 0);
        run(5 * L + 2);
        check_results("nominal", 65, 1, 110, 130);

        // Reset mid-DWELL of the first point.
        start_sweep(100, 140, 10, 0);
        run(6);
        rst = 1'b1;
        t0 = -1; idle_k = 0; idle_found = 1'b0; idle_lo = 0; idle_hi = 0;
        #1;
        check_all_zero("async_rst");
        run(2);
        rst = 1'b0;
        run(5);
        check("post_rst busy", int'(busy_o), 0);

        // Most negative error code must not look locked.
        start_sweep(100, 140, 10, 1);
        run(5 * L + 2);
        check_results("sat_neg", 65, 0, 0, 0);

        // Carry out of the top of the k range: single point, tolerance-edge error.
        start_sweep(16'hFFF0, 16'hFFFF, 16'h0020, 2);
        run(L + 2);
        check_results("carry", 13, 1, 65520, 65520);
        check("carry k_val", int'(k_val_o), 65520);

        start_sweep(16'hFFF0, 16'hFFFF, 0, 2);
        run(L + 2);
        check_results("step0", 13, 1, 65520, 65520);

        // start > stop, error just above tolerance.
        start_sweep(200, 100, 10, 5);
        run(L + 2);
        check_results("rev_range", 13, 0, 0, 0);
        check("rev_range k_val", int'(k_val_o), 200);

        // One-cycle glitch in DWELL at k=120.
        start_sweep(100, 140, 10, 3);
        run(5 * L + 2);
`ifdef LOCK_SWEEP_EARLY_STOP_EN
        check_results("dwell_glitch", 39, 1, 110, 110);
`else
        check_results("dwell_glitch", 65, 1, 110, 130);
`endif

        // Same glitch during SETTLE is ignored.
        start_sweep(100, 140, 10, 4);
        run(5 * L + 2);
        check_results("settle_glitch", 65, 1, 110, 130);

        // Abort during the second DWELL window.
        start_sweep(100, 140, 10, 0);
        for (int g = 0; g < 100 && (cyc + 1 - t0) != 19; g++) tick();
        check("abort reached", cyc + 1 - t0, 19);
        abort_i = 1'b1;
        abort_rel = 19;
        tick();
        abort_i = 1'b0;
        check("abort busy", int'(busy_o), 0);
        check("abort osc_en", int'(osc_enable_o), 0);
        check("abort k_val", int'(k_val_o), 110);
        check("abort found", int'(found_o), 0);
        run(10);
        check("abort done_cnt", done_cnt, 0);

        // start and abort together in IDLE: no sweep.
        start_i = 1'b1;
        abort_i = 1'b1;
        tick();
        start_i = 1'b0;
        abort_i = 1'b0;
        run(3);
        check("start_abort busy", int'(busy_o), 0);
        check("start_abort done_cnt", done_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
